pixel_sequencer: RTL

- Frame-level controller for the pixel array.
- Per frame it drives the shared ERASE, EXPOSE and VBN1 controls, runs a ramp-conversion phase with a shared DATA count bus, then reads rows out one at a time with a per-row strobe.
- Frame start uses a START/BUSY/DONE handshake with the readout/host logic.
- It sits between the array (all pixel instances share its outputs) and the frame buffer/host interface.

---
 rtl/pixel_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pixel_sequencer.sv
// Frame controller for the pixel array: erase, exposure pulse train, ramp
// conversion and row-by-row readout, started by a START/BUSY/DONE handshake.
module pixel_sequencer #(
  parameter int N_PULSE    = 20,
  parameter int C_ERASE    = 5,
  parameter int RESOLUTION = 8,
  parameter int ROWS       = 4,
  parameter int C_READ     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  START,
  input  logic                  ABORT,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  VBN1,
  output logic                  CONVERT,
  output logic [RESOLUTION-1:0] DATA,
  output logic [ROWS-1:0]       ROW_SEL,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int EXP_LEN  = 2 * N_PULSE;
  localparam int CONV_LEN = 1 << RESOLUTION;
  localparam int READ_LEN = ROWS * C_READ;
  localparam int MAX_A    = (EXP_LEN > CONV_LEN) ? EXP_LEN : CONV_LEN;
  localparam int MAX_B    = (C_ERASE > READ_LEN) ? C_ERASE : READ_LEN;
  localparam int MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_FINISH
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count, next_count;
  logic [RW-1:0]   row, next_row;

  logic                  next_erase;
  logic                  next_expose;
  logic                  next_vbn1;
  logic                  next_convert;
  logic [RESOLUTION-1:0] next_data;
  logic [ROWS-1:0]       next_row_sel;
  logic                  next_busy;
  logic                  next_done;

  // State, counters and all outputs are flops; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      row     <= '0;
      ERASE   <= 1'b0;
      EXPOSE  <= 1'b0;
      VBN1    <= 1'b0;
      CONVERT <= 1'b0;
      DATA    <= '0;
      ROW_SEL <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      row     <= next_row;
      ERASE   <= next_erase;
      EXPOSE  <= next_expose;
      VBN1    <= next_vbn1;
      CONVERT <= next_convert;
      DATA    <= next_data;
      ROW_SEL <= next_row_sel;
      BUSY    <= next_busy;
      DONE    <= next_done;
    end
  end

  // Phase sequencing; the counter restarts at zero on every state entry.
  always_comb begin
    next_state = state;
    next_count = count + CW'(1);
    next_row   = row;
    unique case (state)
      S_IDLE: begin
        next_count = '0;
        next_row   = '0;
        if (START) next_state = S_ERASE;
      end
      S_ERASE: begin
        if (count == CW'(C_ERASE - 1)) begin
          next_state = S_EXPOSE;
          next_count = '0;
        end
      end
      S_EXPOSE: begin
        if (count == CW'(EXP_LEN - 1)) begin
          next_state = S_CONVERT;
          next_count = '0;
        end
      end
      S_CONVERT: begin
        if (count == CW'(CONV_LEN - 1)) begin
          next_state = S_READ;
          next_count = '0;
          next_row   = '0;
        end
      end
      S_READ: begin
        if (count == CW'(C_READ - 1)) begin
          next_count = '0;
          if (row == RW'(ROWS - 1)) next_state = S_FINISH;
          else                      next_row   = row + RW'(1);
        end
      end
      S_FINISH: begin
        next_state = S_IDLE;
        next_count = '0;
        next_row   = '0;
      end
      default: begin
        next_state = S_IDLE;
        next_count = '0;
        next_row   = '0;
      end
    endcase
    // Abort outranks every phase-end transition.
    if (state != S_IDLE && ABORT) begin
      next_state = S_IDLE;
      next_count = '0;
      next_row   = '0;
    end
  end

  always_comb begin
    next_erase   = (next_state == S_ERASE);
    next_expose  = (next_state == S_EXPOSE);
    next_vbn1    = (next_state == S_EXPOSE) && next_count[0];
    next_convert = (next_state == S_CONVERT);
    next_data    = (next_state == S_CONVERT) ? next_count[RESOLUTION-1:0] : '0;
    next_row_sel = (next_state == S_READ) ? (ROWS'(1) << next_row) : '0;
    next_busy    = (next_state != S_IDLE);
    next_done    = (next_state == S_FINISH);
  end

endmodule
